// File: rtl/uart_ext_pkg.sv
// Shared types and helpers for the extended UART core.
package uart_ext_pkg;

    localparam int MIN_DIV = 4;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } par_e;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    // Mask covering the active data bits (5..8) for a cfg_dbits code.
    function automatic logic [7:0] dbits_mask(input logic [1:0] dbits);
        return 8'hFF >> (2'd3 - dbits);
    endfunction

    // Code 3 is an alias for no parity.
    function automatic par_e par_decode(input logic [1:0] p);
        return (p == 2'd3) ? PAR_NONE : par_e'(p);
    endfunction

endpackage

// File: rtl/uart_ext_fifo.sv
// Synchronous FIFO with registered count/full/empty; head is read combinationally.
module uart_ext_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      cnt_d;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr];

    // Next fill level from accepted push/pop.
    always_comb begin
        cnt_d = count;
        if (do_push && !do_pop)
            cnt_d = count + ONE;
        else if (do_pop && !do_push)
            cnt_d = count - ONE;
    end

    // Pointers and registered status.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= cnt_d;
            full  <= (cnt_d == (AW+1)'(DEPTH));
            empty <= (cnt_d == '0);
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/uart_ext_core.sv
// UART core: TX/RX engines with runtime framing config and a FIFO per direction.
module uart_ext_core
    import uart_ext_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          cfg_en,
    input  logic [1:0]                    cfg_dbits,
    input  logic [1:0]                    cfg_par,
    input  logic                          cfg_stop,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_req,
    output logic                          tx_full,
    output logic                          tx_empty,
    output logic                          tx_busy,
    output logic [7:0]                    rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_valid,
    input  logic                          rx_ack,
    output logic                          rx_ovr,
    input  logic                          err_clr,
    output logic [$clog2(FIFO_DEPTH):0]   tx_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   rx_cnt,
    output logic                          uart_tx,
    input  logic                          uart_rx
);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] div_eff;
    assign div_eff = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;

    // ---------------- TX ----------------
    tx_state_e        tx_state, tx_nxt;
    logic [DIV_W-1:0] tx_ctr, tx_ctr_d, tx_div_l;
    logic [2:0]       tx_idx, tx_idx_d;
    logic [7:0]       tx_sh, tx_sh_d, tx_head;
    logic             tx_pbit, tx_pbit_d, tx_line_d, tx_pop, tx_load, tx_tick;
    logic [1:0]       tx_dbits_l;
    par_e             tx_par_l;
    logic             tx_stop_l;

    uart_ext_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .resetn(resetn), .push(tx_req), .din(tx_data), .pop(tx_pop),
        .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
    );

    assign tx_busy = (tx_state != TX_IDLE) || tx_pop;

    // TX next state; a finished stop bit chains straight into the next start bit.
    always_comb begin
        tx_nxt    = tx_state;
        tx_ctr_d  = tx_ctr + ONE;
        tx_idx_d  = tx_idx;
        tx_sh_d   = tx_sh;
        tx_pbit_d = tx_pbit;
        tx_load   = 1'b0;
        tx_pop    = 1'b0;
        tx_tick   = (tx_ctr == tx_div_l - ONE);
        case (tx_state)
            TX_IDLE: begin
                tx_ctr_d = '0;
                tx_load  = ~tx_empty;
            end
            TX_START: if (tx_tick) begin
                tx_nxt = TX_DATA; tx_ctr_d = '0; tx_idx_d = '0;
            end
            TX_DATA: if (tx_tick) begin
                tx_ctr_d = '0;
                tx_sh_d  = tx_sh >> 1;
                tx_idx_d = tx_idx + 3'd1;
                if (tx_idx == 3'(tx_dbits_l) + 3'd4)
                    tx_nxt = (tx_par_l != PAR_NONE) ? TX_PARITY : TX_STOP1;
            end
            TX_PARITY: if (tx_tick) begin
                tx_nxt = TX_STOP1; tx_ctr_d = '0;
            end
            TX_STOP1: if (tx_tick) begin
                tx_ctr_d = '0;
                if (tx_stop_l)      tx_nxt  = TX_STOP2;
                else if (!tx_empty) tx_load = 1'b1;
                else                tx_nxt  = TX_IDLE;
            end
            TX_STOP2: if (tx_tick) begin
                tx_ctr_d = '0;
                if (!tx_empty) tx_load = 1'b1;
                else           tx_nxt  = TX_IDLE;
            end
            default: tx_nxt = TX_IDLE;
        endcase
        if (!cfg_en) begin
            tx_nxt = TX_IDLE; tx_load = 1'b0; tx_ctr_d = '0;
        end
        if (tx_load) begin
            tx_pop    = 1'b1;
            tx_nxt    = TX_START;
            tx_ctr_d  = '0;
            tx_sh_d   = tx_head;
            tx_pbit_d = ^(tx_head & dbits_mask(cfg_dbits)) ^ (par_decode(cfg_par) == PAR_ODD);
        end
        case (tx_nxt)
            TX_START:  tx_line_d = 1'b0;
            TX_DATA:   tx_line_d = tx_sh_d[0];
            TX_PARITY: tx_line_d = tx_pbit_d;
            default:   tx_line_d = 1'b1;
        endcase
    end

    // TX registers; the line is registered so it is glitch-free and resets high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state   <= TX_IDLE;
            tx_ctr     <= '0;
            tx_idx     <= '0;
            tx_sh      <= '0;
            tx_pbit    <= 1'b0;
            tx_dbits_l <= 2'd3;
            tx_par_l   <= PAR_NONE;
            tx_stop_l  <= 1'b0;
            tx_div_l   <= DIV_W'(MIN_DIV);
            uart_tx    <= 1'b1;
        end else begin
            tx_state <= tx_nxt;
            tx_ctr   <= tx_ctr_d;
            tx_idx   <= tx_idx_d;
            tx_sh    <= tx_sh_d;
            tx_pbit  <= tx_pbit_d;
            uart_tx  <= tx_line_d;
            if (tx_load) begin
                tx_dbits_l <= cfg_dbits;
                tx_par_l   <= par_decode(cfg_par);
                tx_stop_l  <= cfg_stop;
                tx_div_l   <= div_eff;
            end
        end
    end

    // ---------------- RX ----------------
    rx_state_e        rx_state, rx_nxt;
    logic [DIV_W-1:0] rx_ctr, rx_ctr_d, rx_div_l;
    logic [2:0]       rx_idx, rx_idx_d;
    logic [7:0]       rx_sh, rx_sh_d;
    logic             rx_perr_q, rx_perr_d, rx_push, rx_start, rx_full, rx_empty;
    logic [1:0]       rx_sync;
    logic             rx_prev, rx_s;
    logic [1:0]       rx_dbits_l;
    par_e             rx_par_l;
    rx_entry_t        rx_in, rx_head;

    assign rx_s  = rx_sync[1];
    assign rx_in = '{ferr: ~rx_s, perr: rx_perr_q, data: rx_sh};

    uart_ext_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .resetn(resetn), .push(rx_push), .din(rx_in), .pop(rx_ack),
        .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
    );

    assign rx_valid = ~rx_empty;
    assign rx_data  = rx_valid ? rx_head.data : 8'h00;
    assign rx_perr  = rx_valid & rx_head.perr;
    assign rx_ferr  = rx_valid & rx_head.ferr;

    // RX next state: mid-start recheck, then one sample per bit time.
    always_comb begin
        rx_nxt    = rx_state;
        rx_ctr_d  = rx_ctr + ONE;
        rx_idx_d  = rx_idx;
        rx_sh_d   = rx_sh;
        rx_perr_d = rx_perr_q;
        rx_push   = 1'b0;
        rx_start  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_ctr_d = '0;
                if (rx_prev && !rx_s) begin
                    rx_start = 1'b1; rx_nxt = RX_START; rx_sh_d = '0; rx_perr_d = 1'b0;
                end
            end
            RX_START: if (rx_ctr == (rx_div_l >> 1) - ONE) begin
                rx_ctr_d = '0; rx_idx_d = '0;
                rx_nxt   = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_ctr == rx_div_l - ONE) begin
                rx_ctr_d        = '0;
                rx_sh_d[rx_idx] = rx_s;
                rx_idx_d        = rx_idx + 3'd1;
                if (rx_idx == 3'(rx_dbits_l) + 3'd4)
                    rx_nxt = (rx_par_l != PAR_NONE) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_ctr == rx_div_l - ONE) begin
                rx_ctr_d  = '0;
                rx_perr_d = (^rx_sh ^ rx_s) != (rx_par_l == PAR_ODD);
                rx_nxt    = RX_STOP;
            end
            RX_STOP: if (rx_ctr == rx_div_l - ONE) begin
                rx_push = 1'b1; rx_nxt = RX_IDLE;
            end
            default: rx_nxt = RX_IDLE;
        endcase
        if (!cfg_en) begin
            rx_nxt = RX_IDLE; rx_push = 1'b0; rx_start = 1'b0; rx_ctr_d = '0;
        end
    end

    // RX registers, synchroniser and sticky overrun.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_sync    <= 2'b11;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_ctr     <= '0;
            rx_idx     <= '0;
            rx_sh      <= '0;
            rx_perr_q  <= 1'b0;
            rx_dbits_l <= 2'd3;
            rx_par_l   <= PAR_NONE;
            rx_div_l   <= DIV_W'(MIN_DIV);
            rx_ovr     <= 1'b0;
        end else begin
            rx_sync   <= {rx_sync[0], uart_rx};
            rx_prev   <= rx_s;
            rx_state  <= rx_nxt;
            rx_ctr    <= rx_ctr_d;
            rx_idx    <= rx_idx_d;
            rx_sh     <= rx_sh_d;
            rx_perr_q <= rx_perr_d;
            if (rx_start) begin
                rx_dbits_l <= cfg_dbits;
                rx_par_l   <= par_decode(cfg_par);
                rx_div_l   <= div_eff;
            end
            if (rx_push && rx_full) rx_ovr <= 1'b1;
            else if (err_clr)       rx_ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_ext_core.sv
// Bench for uart_ext_core: RX vector table, TX waveform, loopback, overrun, glitch, reset.
module tb_uart_ext_core;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        cfg_en = 1'b1, cfg_stop = 1'b0;
    logic [1:0]  cfg_dbits = 2'd3, cfg_par = 2'd0;
    logic [15:0] cfg_div = 16'd8;
    logic [7:0]  tx_data = 8'h00, rx_data;
    logic        tx_req = 1'b0, tx_full, tx_empty, tx_busy;
    logic        rx_perr, rx_ferr, rx_valid, rx_ack = 1'b0, rx_ovr, err_clr = 1'b0;
    logic [2:0]  tx_cnt, rx_cnt;
    logic        uart_tx, uart_rx, loop_en = 1'b0, rx_drv = 1'b1;

    assign uart_rx = loop_en ? uart_tx : rx_drv;

    uart_ext_core #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clk(clk), .resetn(resetn), .cfg_en(cfg_en), .cfg_dbits(cfg_dbits),
        .cfg_par(cfg_par), .cfg_stop(cfg_stop), .cfg_div(cfg_div),
        .tx_data(tx_data), .tx_req(tx_req), .tx_full(tx_full), .tx_empty(tx_empty),
        .tx_busy(tx_busy), .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
        .rx_valid(rx_valid), .rx_ack(rx_ack), .rx_ovr(rx_ovr), .err_clr(err_clr),
        .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] dbits;
        logic [1:0] par;
        logic       stop;
        logic [15:0] div;
        int         drv_div;
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        logic [9:0] exp;      // {ferr, perr, data}
    } vec_t;

    vec_t       vt [6];
    logic [9:0] exp_q [$];
    int         n_pass = 0, n_total = 0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        else n_pass++;
    endtask

    task automatic drive_bit(input logic v, input int dv);
        rx_drv = v;
        repeat (dv) tick();
    endtask

    // Serial frame onto uart_rx, with optional corrupted parity / stop bit.
    task automatic send_rx(input logic [7:0] d, input int n, input int par, input bit st2,
                           input int dv, input bit bp, input bit bs);
        logic [7:0] m;
        logic       p;
        m = 8'hFF >> (8 - n);
        p = (^(d & m)) ^ (par == 2) ^ bp;
        drive_bit(1'b0, dv);
        for (int i = 0; i < n; i++) drive_bit(d[i], dv);
        if (par == 1 || par == 2) drive_bit(p, dv);
        drive_bit(~bs, dv);
        if (st2) drive_bit(1'b1, dv);
        drive_bit(1'b1, dv);
    endtask

    task automatic wait_valid(input int budget, input string nm);
        for (int i = 0; i < budget && !rx_valid; i++) tick();
        chk(nm, rx_valid, 1);
    endtask

    // Compare the RX head against the scoreboard front, then pop it.
    task automatic pop_check(input string nm);
        logic [9:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
        chk(nm, {rx_ferr, rx_perr, rx_data}, e);
        rx_ack = 1'b1; tick(); rx_ack = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_data = d; tx_req = 1'b1; tick(); tx_req = 1'b0;
    endtask

    initial begin
        int errs;
        logic [7:0] a5;
        vt[0] = '{2'd3, 2'd0, 1'b0, 16'd8,  8,  8'hA5, 1'b0, 1'b0, {2'b00, 8'hA5}};
        vt[1] = '{2'd0, 2'd1, 1'b1, 16'd6,  6,  8'hFF, 1'b0, 1'b0, {2'b00, 8'h1F}};
        vt[2] = '{2'd2, 2'd2, 1'b0, 16'd3,  4,  8'h2B, 1'b0, 1'b0, {2'b00, 8'h2B}};
        vt[3] = '{2'd3, 2'd2, 1'b0, 16'd8,  8,  8'h3C, 1'b1, 1'b1, {2'b11, 8'h3C}};
        vt[4] = '{2'd3, 2'd1, 1'b0, 16'd10, 10, 8'h00, 1'b1, 1'b0, {2'b01, 8'h00}};
        vt[5] = '{2'd1, 2'd1, 1'b0, 16'd8,  8,  8'h15, 1'b0, 1'b1, {2'b10, 8'h15}};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_tx_empty", tx_empty, 1);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_entry", {rx_ferr, rx_perr, rx_data}, 0);
        chk("rst_rx_ovr", rx_ovr, 0);
        chk("rst_cnts", {tx_cnt, rx_cnt}, 0);
        @(negedge clk) resetn = 1'b1;
        tick();

        // TX 0xA5, 8N1, div 8: latency and full waveform
        a5 = 8'hA5;
        tx_data = a5; tx_req = 1'b1;
        tick(); tx_req = 1'b0;
        chk("tx_lat_empty", tx_empty, 0);
        chk("tx_lat_busy", tx_busy, 1);
        errs = 0;
        for (int k = 0; k < 80; k++) begin
            logic e;
            tick();
            e = (k < 8) ? 1'b0 : (k >= 72) ? 1'b1 : a5[k/8 - 1];
            if (uart_tx !== e) errs++;
        end
        chk("tx_wave_errs", errs, 0);
        tick();
        chk("tx_busy_end", tx_busy, 0);
        chk("tx_idle_line", uart_tx, 1);

        // Loopback 7E2, div 16: two back-to-back frames
        cfg_dbits = 2'd2; cfg_par = 2'd1; cfg_stop = 1'b1; cfg_div = 16'd16;
        loop_en = 1'b1;
        push_tx(8'h55); push_tx(8'h2A);
        exp_q.push_back({2'b00, 8'h55});
        exp_q.push_back({2'b00, 8'h2A});
        for (int i = 0; i < 1200 && rx_cnt != 3'd2; i++) tick();
        chk("loop_rx_cnt", rx_cnt, 2);
        pop_check("loop_entry0");
        pop_check("loop_entry1");
        for (int i = 0; i < 400 && tx_busy; i++) tick();
        chk("loop_tx_done", tx_busy, 0);
        loop_en = 1'b0;
        tick();

        // RX vector table
        for (int i = 0; i < 6; i++) begin
            cfg_dbits = vt[i].dbits; cfg_par = vt[i].par;
            cfg_stop = vt[i].stop; cfg_div = vt[i].div;
            send_rx(vt[i].data, int'(vt[i].dbits) + 5, int'(vt[i].par), vt[i].stop,
                    vt[i].drv_div, vt[i].bad_par, vt[i].bad_stop);
            exp_q.push_back(vt[i].exp);
            wait_valid(200, $sformatf("vec%0d_valid", i));
            pop_check($sformatf("vec%0d_entry", i));
            chk($sformatf("vec%0d_drained", i), rx_valid, 0);
        end

        // Short low glitch must be rejected, then a real frame still lands
        cfg_dbits = 2'd3; cfg_par = 2'd0; cfg_stop = 1'b0; cfg_div = 16'd16;
        rx_drv = 1'b0; tick(); tick(); rx_drv = 1'b1;
        repeat (40) tick();
        chk("glitch_no_push", {rx_valid, rx_cnt}, 0);
        send_rx(8'h5A, 8, 0, 1'b0, 16, 1'b0, 1'b0);
        exp_q.push_back({2'b00, 8'h5A});
        wait_valid(100, "glitch_next_valid");
        pop_check("glitch_next_entry");

        // Overrun: five frames into a 4-deep FIFO
        cfg_div = 16'd8;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            b = 8'(8'h11 * (i + 1));
            send_rx(b, 8, 0, 1'b0, 8, 1'b0, 1'b0);
            if (i < 4) exp_q.push_back({2'b00, b});
        end
        chk("ovr_rx_cnt", rx_cnt, 4);
        chk("ovr_flag", rx_ovr, 1);
        for (int i = 0; i < 4; i++) pop_check($sformatf("ovr_entry%0d", i));
        chk("ovr_sticky", rx_ovr, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("ovr_cleared", rx_ovr, 0);

        // Reset in the middle of a TX frame with entries queued
        push_tx(8'h81); push_tx(8'h42); push_tx(8'h24);
        repeat (20) tick();
        chk("mid_busy", tx_busy, 1);
        @(negedge clk) resetn = 1'b0;
        #1;
        chk("mid_rst_line", uart_tx, 1);
        chk("mid_rst_empty", tx_empty, 1);
        chk("mid_rst_cnt", tx_cnt, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        errs = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) errs++;
        end
        chk("mid_no_more_frames", errs, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
